sensor_monitor_ctrl: RTL and testbench
======================================

// Module: sensor_monitor_ctrl
// PURPOSE
//  Periodic sampling/qualification controller for the 4-bit sensor error bus.
//  - Samples sensors[3:0] on an internal prescaled tick.
//  - Evaluates err = s[0] | (s[1] & (s[2] | s[3])).
//  - Debounces err over consecutive samples, then raises a sticky fault with a
//    captured sensor snapshot and a saturating fault-event count.
//  - Sits between raw sensor inputs and the system fault/interrupt logic.
// PARAMETERS
//  PRESCALE   4  cycles between samples, >=1 (1 = sample every cycle)
//  DEBOUNCE   3  consecutive errored samples required to declare fault, >=1
//  CNT_BITS   8  width of fault_count
// PORTS
//  clk            in   1         system clock, rising edge
//  n_rst          in   1         asynchronous active-low reset
//  enable         in   1         1 = monitoring active
//  sensors        in   4         raw sensor bus (synchronous to clk)
//  clear_fault    in   1         level/pulse; releases a latched fault
//  sample_strobe  out  1         1-cycle pulse on each sample tick
//  fault          out  1         sticky qualified-fault flag (registered)
//  fault_code     out  4         sensors value at the qualifying sample
//  fault_count    out  CNT_BITS  number of faults declared, saturating
// BEHAVIOUR
//  Reset (async, n_rst=0): state=IDLE; prescaler=0; deb_cnt=0; all outputs=0.
//  FSM states: IDLE, MONITOR, PENDING, FAULT (all transitions registered).
//  Prescaler:
//   - Counts only in MONITOR/PENDING; held at 0 in IDLE and FAULT.
//   - sample_strobe=1 when count==PRESCALE-1, then count wraps to 0.
//   - First strobe occurs PRESCALE cycles after entering MONITOR.
//   - Strobe is never asserted in IDLE or FAULT.
//  Transitions; "tick" = sample_strobe=1 in that cycle:
//   IDLE:    enable=1 -> MONITOR.
//   MONITOR: enable=0 -> IDLE.
//            tick & err -> PENDING with deb_cnt=1.
//            If DEBOUNCE==1, tick & err -> FAULT directly.
//   PENDING: enable=0 -> IDLE, deb_cnt=0.
//            tick & !err -> MONITOR, deb_cnt=0.
//            tick & err -> deb_cnt+1; when deb_cnt+1==DEBOUNCE -> FAULT.
//   FAULT:   clear_fault=1 -> MONITOR if enable=1, else IDLE.
//            enable is ignored otherwise; the fault is sticky.
//  On the qualifying tick (registered, visible next cycle):
//   - fault<=1; fault_code<=sensors sampled that cycle.
//   - fault_count<=fault_count+1, saturating at all-ones (no wrap).
//   - deb_cnt<=0.
//  Fault latency: fault rises 1 cycle after the DEBOUNCE-th consecutive
//  errored tick.
//  Release: fault falls 1 cycle after clear_fault is sampled in FAULT.
//  fault_code holds until the next declared fault.
//  fault_count is cleared only by reset.
//  Simultaneous events, priority enable=0 > tick:
//   - enable=0 in the same cycle as a qualifying tick -> IDLE, no fault.
//   - clear_fault outside FAULT is ignored, including during the qualifying
//     tick; FAULT is still entered.
//  Sensor bus: no internal synchroniser; sensors are only evaluated on a tick.
// STRUCTURE
//  Package sensor_mon_pkg:
//   - state_t enum {IDLE, MONITOR, PENDING, FAULT}.
//   - function sensor_err(logic [3:0]) returning err.
//  Sub-module sample_timer (parameterised rollover counter):
//   - Inputs: clk, n_rst, clear, count_enable.
//   - Output: rollover_flag, which drives sample_strobe.
//  Top level: FSM, deb_cnt, fault/fault_code/fault_count registers.
// TESTING (PRESCALE=4, DEBOUNCE=3, CNT_BITS=8 unless noted)
//  1. Reset, then enable=1, sensors=4'b0000 for 40 cycles.
//     -> strobe every 4th cycle, first strobe 4 cycles after MONITOR entry;
//        fault=0; fault_count=0.
//  2. sensors=4'b0101 held for 3 ticks.
//     -> fault=1 one cycle after 3rd tick; fault_code=4'b0101; fault_count=1;
//        strobes stop.
//  3. sensors pattern 1010, 1010, 0000 (err, err, clean), then 1010 x3.
//     -> no fault after the first two; fault on the 6th tick;
//        fault_code=4'b1010.
//  4. In FAULT, enable=0 then clear_fault pulse.
//     -> fault=0 next cycle; state=IDLE; no strobes until enable=1;
//        fault_code unchanged.
//  5. CNT_BITS=2: declare and clear 5 faults.
//     -> fault_count sequence 1,2,3,3,3 (saturation).
//  6. Assert n_rst=0 while in PENDING (deb_cnt=2).
//     -> outputs 0 immediately; after release and 2 errored ticks, no fault
//        (debounce restarted).

Source files
------------

// File: rtl/sensor_mon_pkg.sv
// Shared types and the sensor error equation for the sensor monitor controller.
package sensor_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MONITOR,
        PENDING,
        FAULT
    } state_t;

    // A sensor word is in error when bit 0 fires, or bit 1 fires together with bit 2 or bit 3.
    function automatic logic sensor_err(input logic [3:0] s);
        return s[0] | (s[1] & (s[2] | s[3]));
    endfunction

endpackage

// File: rtl/sample_timer.sv
// Rollover counter producing a one-cycle flag every PRESCALE enabled cycles.
module sample_timer #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic count_enable,
    output logic rollover_flag
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        rollover_flag = count_enable && (count_q == LAST);
        count_d       = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = rollover_flag ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sensor_monitor_ctrl.sv
// Samples the sensor error bus on a prescaled tick, debounces errors and latches a sticky fault.
module sensor_monitor_ctrl
    import sensor_mon_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int DEBOUNCE = 3,
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                enable,
    input  logic [3:0]          sensors,
    input  logic                clear_fault,
    output logic                sample_strobe,
    output logic                fault,
    output logic [3:0]          fault_code,
    output logic [CNT_BITS-1:0] fault_count
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

    state_t                state_q, state_d;
    logic [DW-1:0]         deb_cnt_q, deb_cnt_d;
    logic                  fault_q, fault_d;
    logic [3:0]            fault_code_q, fault_code_d;
    logic [CNT_BITS-1:0]   fault_count_q, fault_count_d;
    logic                  tick;
    logic                  err;
    logic                  declare;
    logic                  timer_clear;
    logic                  timer_run;

    // The prescaler only runs while actively watching the sensors.
    assign timer_clear = (state_q == IDLE) || (state_q == FAULT);
    assign timer_run   = !timer_clear;

    sample_timer #(
        .PRESCALE(PRESCALE)
    ) u_sample_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (timer_clear),
        .count_enable (timer_run),
        .rollover_flag(tick)
    );

    always_comb begin
        state_d       = state_q;
        deb_cnt_d     = deb_cnt_q;
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;
        fault_count_d = fault_count_q;
        declare       = 1'b0;
        err           = sensor_err(sensors);

        unique case (state_q)
            IDLE: begin
                if (enable) state_d = MONITOR;
            end
            MONITOR: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick && err) begin
                    if (DEBOUNCE == 1) begin
                        declare = 1'b1;
                    end else begin
                        state_d   = PENDING;
                        deb_cnt_d = DW'(1);
                    end
                end
            end
            PENDING: begin
                if (!enable) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (tick) begin
                    if (!err) begin
                        state_d   = MONITOR;
                        deb_cnt_d = '0;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        declare = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
            end
            FAULT: begin
                // Only clear_fault leaves FAULT; enable merely picks the destination.
                if (clear_fault) begin
                    state_d = enable ? MONITOR : IDLE;
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (declare) begin
            state_d      = FAULT;
            deb_cnt_d    = '0;
            fault_d      = 1'b1;
            fault_code_d = sensors;
            if (fault_count_q != '1) fault_count_d = fault_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            deb_cnt_q     <= '0;
            fault_q       <= 1'b0;
            fault_code_q  <= '0;
            fault_count_q <= '0;
        end else begin
            state_q       <= state_d;
            deb_cnt_q     <= deb_cnt_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign sample_strobe = tick;
    assign fault         = fault_q;
    assign fault_code    = fault_code_q;
    assign fault_count   = fault_count_q;

endmodule

// File: tb/tb_sensor_monitor_ctrl.sv
// Scoreboard bench: a cycle-level behavioural model queues expected strobe/fault events, a monitor pops and compares.
module tb_sensor_monitor_ctrl;

    localparam int PRESCALE = 4;
    localparam int DEBOUNCE = 3;
    localparam int CNT_BITS = 8;
    localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

    localparam int EV_STROBE = 0;
    localparam int EV_RISE   = 1;
    localparam int EV_FALL   = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] code;
        logic [7:0] count;
    } ev_t;

    logic                clk = 1'b0;
    logic                n_rst = 1'b0;
    logic                enable = 1'b0;
    logic [3:0]          sensors = 4'h0;
    logic                clear_fault = 1'b0;
    logic                sample_strobe;
    logic                fault;
    logic [3:0]          fault_code;
    logic [CNT_BITS-1:0] fault_count;

    logic                s_enable = 1'b0;
    logic [3:0]          s_sensors = 4'h0;
    logic                s_clear = 1'b0;
    logic                s_strobe;
    logic                s_fault;
    logic [3:0]          s_fault_code;
    logic [1:0]          s_fault_count;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc = 0;
    ev_t exp_q[$];

    // Reference model: "active" means watching sensors; phase counts cycles spent watching.
    bit         m_active;
    bit         m_faulted;
    int         m_phase;
    int         m_streak;
    bit         m_fault;
    logic [3:0] m_code;
    int         m_count;
    bit         m_prev_fault;
    bit         m_last_strobe;
    bit         dut_prev_fault = 1'b0;

    sensor_monitor_ctrl #(
        .PRESCALE(PRESCALE),
        .DEBOUNCE(DEBOUNCE),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .sensors      (sensors),
        .clear_fault  (clear_fault),
        .sample_strobe(sample_strobe),
        .fault        (fault),
        .fault_code   (fault_code),
        .fault_count  (fault_count)
    );

    sensor_monitor_ctrl #(
        .PRESCALE(1),
        .DEBOUNCE(1),
        .CNT_BITS(2)
    ) u_small (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (s_enable),
        .sensors      (s_sensors),
        .clear_fault  (s_clear),
        .sample_strobe(s_strobe),
        .fault        (s_fault),
        .fault_code   (s_fault_code),
        .fault_count  (s_fault_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic bit spec_err(input logic [3:0] s);
        return s[0] | (s[1] & (s[2] | s[3]));
    endfunction

    task automatic model_reset();
        m_active      = 1'b0;
        m_faulted     = 1'b0;
        m_phase       = 0;
        m_streak      = 0;
        m_fault       = 1'b0;
        m_code        = 4'h0;
        m_count       = 0;
        m_prev_fault  = 1'b0;
        m_last_strobe = 1'b0;
    endtask

    task automatic push_event(input int kind);
        ev_t e;
        e.kind  = kind;
        e.cyc   = cyc;
        e.code  = m_code;
        e.count = 8'(m_count);
        exp_q.push_back(e);
    endtask

    // Emit this cycle's expected events, then advance the model with the inputs seen this cycle.
    task automatic model_step(input bit en, input logic [3:0] s, input bit clr);
        bit strobe;
        strobe = m_active && (m_phase == PRESCALE - 1);
        m_last_strobe = strobe;
        if (strobe) push_event(EV_STROBE);
        if (m_fault != m_prev_fault) push_event(m_fault ? EV_RISE : EV_FALL);
        m_prev_fault = m_fault;

        if (m_faulted) begin
            if (clr) begin
                m_faulted = 1'b0;
                m_fault   = 1'b0;
                m_active  = en;
                m_phase   = 0;
            end
        end else if (m_active) begin
            if (!en) begin
                m_active = 1'b0;
                m_streak = 0;
                m_phase  = 0;
            end else begin
                m_phase = (m_phase + 1) % PRESCALE;
                if (strobe) begin
                    if (spec_err(s)) begin
                        m_streak++;
                        if (m_streak == DEBOUNCE) begin
                            m_faulted = 1'b1;
                            m_active  = 1'b0;
                            m_fault   = 1'b1;
                            m_code    = s;
                            m_count   = (m_count < CNT_MAX) ? m_count + 1 : m_count;
                            m_streak  = 0;
                            m_phase   = 0;
                        end
                    end else begin
                        m_streak = 0;
                    end
                end
            end
        end else if (en) begin
            m_active = 1'b1;
            m_phase  = 0;
        end
    endtask

    task automatic apply_stimulus(input bit en, input logic [3:0] s, input bit clr);
        @(posedge clk);
        #1;
        enable      = en;
        sensors     = s;
        clear_fault = clr;
        model_step(en, s, clr);
    endtask

    // Hold a sensor value until the model reports a sample tick has consumed it.
    task automatic tick_with(input logic [3:0] s);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * PRESCALE + 2; i++) begin
            apply_stimulus(1'b1, s, 1'b0);
            if (m_last_strobe) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("tick_reached", 32'(seen), 32'd1);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks_total++;
            $display("[TB] FAIL spurious_event: kind %0d at cycle %0d, none expected", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check_output("event_kind", 32'(kind), 32'(e.kind));
            check_output("event_cycle", 32'(cyc), 32'(e.cyc));
            check_output("event_fault_code", 32'(fault_code), 32'(e.code));
            check_output("event_fault_count", 32'(fault_count), 32'(e.count));
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (sample_strobe) observe(EV_STROBE);
            if (fault !== dut_prev_fault) observe(fault ? EV_RISE : EV_FALL);
        end
        dut_prev_fault = fault;
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_strobe"}, 32'(sample_strobe), 32'd0);
        check_output({tag, "_fault"}, 32'(fault), 32'd0);
        check_output({tag, "_fault_code"}, 32'(fault_code), 32'd0);
        check_output({tag, "_fault_count"}, 32'(fault_count), 32'd0);
    endtask

    task automatic small_wait_level(input logic lvl, input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_fault === lvl) break;
        end
        check_output(name, 32'(s_fault), 32'(lvl));
    endtask

    initial begin
        model_reset();
        #3;
        check_reset_outputs("reset");
        check_output("small_reset_count", 32'(s_fault_count), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Clean sensors: regular strobes only.
        repeat (40) apply_stimulus(1'b1, 4'b0000, 1'b0);

        // Persistent error declares a fault after three ticks; strobes then stop.
        repeat (3) tick_with(4'b0101);
        repeat (10) apply_stimulus(1'b1, 4'b0101, 1'b0);

        // Clear back to monitoring; a clean tick breaks the debounce run.
        apply_stimulus(1'b1, 4'b0000, 1'b1);
        tick_with(4'b1010);
        tick_with(4'b1010);
        tick_with(4'b0000);
        repeat (3) tick_with(4'b1010);
        repeat (3) apply_stimulus(1'b0, 4'b0000, 1'b0);

        // Clear with enable low lands in IDLE with no strobes.
        apply_stimulus(1'b0, 4'b0000, 1'b1);
        repeat (10) apply_stimulus(1'b0, 4'b0000, 1'b0);

        // Async reset in the middle of a debounce run.
        tick_with(4'b0101);
        tick_with(4'b0101);
        apply_stimulus(1'b1, 4'b0000, 1'b0);
        #1;
        n_rst       = 1'b0;
        enable      = 1'b0;
        sensors     = 4'h0;
        clear_fault = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        tick_with(4'b0101);
        tick_with(4'b0101);
        tick_with(4'b0000);
        repeat (6) apply_stimulus(1'b1, 4'b0000, 1'b0);
        check_output("no_fault_after_restart", 32'(fault), 32'(m_fault));

        // Randomised traffic, including enable drops and stray clears.
        for (int i = 0; i < 800; i++) begin
            apply_stimulus($urandom_range(0, 19) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
        end
        apply_stimulus(1'b0, 4'b0000, 1'b1);
        repeat (4) apply_stimulus(1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        check_output("leftover_events", 32'(exp_q.size()), 32'd0);

        // Narrow counter instance: fault_count saturates at 3.
        @(posedge clk);
        #1;
        s_enable  = 1'b1;
        s_sensors = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            small_wait_level(1'b1, "small_fault_rise");
            check_output("small_fault_count", 32'(s_fault_count), 32'((i < 3) ? i : 3));
            check_output("small_fault_code", 32'(s_fault_code), 32'h1);
            @(posedge clk);
            #1;
            s_clear = 1'b1;
            @(posedge clk);
            #1;
            s_clear = 1'b0;
            @(negedge clk);
            check_output("small_fault_release", 32'(s_fault), 32'd0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
